// File: rtl/mic_pkg.sv
// mic_pkg: shared I2S framing constants and types for the microphone-array front end.
//   FRAME_BITS : SCK periods per WS frame (left + right slot)
//   SLOT_BITS  : SCK periods per slot
//   MIC_BITS   : microphone word width (signed, MSB first)
//   DATA_FIRST : slot bit index of the MSB (bit 0 is the I2S delay bit)
package mic_pkg;
  localparam int FRAME_BITS = 64;
  localparam int SLOT_BITS  = 32;
  localparam int MIC_BITS   = 24;
  localparam int DATA_FIRST = 1;

  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);
  localparam int SLOT_CNT_W = $clog2(SLOT_BITS);

  typedef logic signed [MIC_BITS-1:0] mic_sample_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } stream_state_t;
endpackage

// File: rtl/i2s_line_deser.sv
// i2s_line_deser: deserialiser for one I2S data line.
//   i_clk, i_rst   : system clock, synchronous active-high reset
//   i_data         : serial data bit of this line
//   i_sck_rise     : 1 in the cycle the shared SCK goes 0->1 (capture strobe)
//   i_slot_bit     : bit position inside the current slot
//   o_word         : completed word (valid only together with o_word_vld)
//   o_word_vld     : 1 in the cycle the last data bit of a slot is captured
module i2s_line_deser
  import mic_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_data,
  input  logic                  i_sck_rise,
  input  logic [SLOT_CNT_W-1:0] i_slot_bit,
  output mic_sample_t           o_word,
  output logic                  o_word_vld
);
  localparam logic [SLOT_CNT_W-1:0] K_FIRST = SLOT_CNT_W'(DATA_FIRST);
  localparam logic [SLOT_CNT_W-1:0] K_LAST  = SLOT_CNT_W'(DATA_FIRST + MIC_BITS - 1);

  logic [MIC_BITS-2:0] r_sr;
  logic                w_in_data;

  assign w_in_data = (i_slot_bit >= K_FIRST) && (i_slot_bit <= K_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst)                         r_sr <= '0;
    else if (i_sck_rise && w_in_data)  r_sr <= {r_sr[MIC_BITS-3:0], i_data};
  end

  // The LSB is presented combinationally so the word can be accumulated
  // in the very cycle it is captured.
  assign o_word     = {r_sr, i_data};
  assign o_word_vld = i_sck_rise && (i_slot_bit == K_LAST);
endmodule

// File: rtl/mic_array_frontend.sv
// mic_array_frontend: I2S mic-array front end. Generates SCK/WS, deserialises
// NUM_LINES stereo lines, box-car averages each channel over DECIM frames and
// streams each batch as NCH channel-tagged AXI-Stream beats.
//   clk_in, rst_in  : system clock, synchronous active-high reset
//   mic_data        : one serial bit per line
//   mic_sck, mic_ws : I2S bit clock / word select (0 = left)
//   m_axis_*        : decimated samples, tuser = 2*line + ws, tlast on last channel
//   overflow_out    : 1-cycle pulse when a batch is dropped (previous still streaming)
module mic_array_frontend
  import mic_pkg::*;
#(
  parameter int NUM_LINES = 2,
  parameter int SCK_DIV   = 16,
  parameter int DECIM     = 8,
  parameter int OUT_W     = 24
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic [NUM_LINES-1:0]           mic_data,
  output logic                           mic_sck,
  output logic                           mic_ws,
  output logic [OUT_W-1:0]               m_axis_tdata,
  output logic [$clog2(2*NUM_LINES)-1:0] m_axis_tuser,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic                           overflow_out
);
  localparam int NCH   = 2 * NUM_LINES;
  localparam int CH_W  = $clog2(NCH);
  localparam int DIV_W = $clog2(SCK_DIV);
  localparam int LOG2D = $clog2(DECIM);
  localparam int ACC_W = MIC_BITS + LOG2D;
  localparam int FC_W  = (LOG2D > 0) ? LOG2D : 1;
  // average (>>> LOG2D) and keep the top OUT_W bits of the MIC_BITS result
  localparam int OUT_SHIFT = LOG2D + MIC_BITS - OUT_W;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(DECIM - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NCH - 1);

  // ---------------- SCK / WS generation ----------------
  logic [DIV_W-1:0]     r_div_cnt;
  logic                 r_sck;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic                 w_tog, w_sck_rise, w_ws;

  assign w_tog      = (r_div_cnt == DIV_LAST);
  assign w_sck_rise = w_tog && !r_sck;
  assign w_ws       = r_bit_cnt[SLOT_CNT_W];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_div_cnt <= '0;
      r_sck     <= 1'b0;
      r_bit_cnt <= '0;
    end else if (w_tog) begin
      r_div_cnt <= '0;
      r_sck     <= ~r_sck;
      if (r_sck) r_bit_cnt <= r_bit_cnt + 1'b1;  // advance on falling toggle
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign mic_sck = r_sck;
  assign mic_ws  = w_ws;

  // ---------------- per-line deserialisers ----------------
  mic_sample_t          w_word [NUM_LINES];
  logic [NUM_LINES-1:0] w_vld;
  logic                 w_cap;

  for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
    i2s_line_deser u_deser (
      .i_clk      (clk_in),
      .i_rst      (rst_in),
      .i_data     (mic_data[l]),
      .i_sck_rise (w_sck_rise),
      .i_slot_bit (r_bit_cnt[SLOT_CNT_W-1:0]),
      .o_word     (w_word[l]),
      .o_word_vld (w_vld[l])
    );
  end

  // all lines share SCK, so their strobes coincide
  assign w_cap = &w_vld;

  // ---------------- accumulate / decimate ----------------
  logic signed [ACC_W-1:0]  r_acc [NCH];
  logic [FC_W-1:0]          r_frame;
  logic                     r_done, r_pend, r_ovf;
  logic [NCH-1:0][OUT_W-1:0] r_buf, w_q;
  stream_state_t            r_state, w_state_nxt;
  logic [CH_W-1:0]          r_ch, w_ch_nxt;

  for (genvar c = 0; c < NCH; c++) begin : g_q
    assign w_q[c] = OUT_W'(r_acc[c] >>> OUT_SHIFT);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int c = 0; c < NCH; c++) r_acc[c] <= '0;
      r_frame <= '0;
      r_done  <= 1'b0;
      r_pend  <= 1'b0;
      r_ovf   <= 1'b0;
      r_buf   <= '0;
    end else begin
      r_done <= w_cap && w_ws && (r_frame == FC_LAST);
      r_pend <= 1'b0;
      r_ovf  <= 1'b0;
      if (w_cap && w_ws) r_frame <= (r_frame == FC_LAST) ? '0 : r_frame + 1'b1;
      if (r_done) begin
        // batch complete: the last right-slot add landed last cycle
        for (int c = 0; c < NCH; c++) r_acc[c] <= '0;
        if (r_state == ST_STREAM) r_ovf <= 1'b1;
        else begin
          r_buf  <= w_q;
          r_pend <= 1'b1;
        end
      end else if (w_cap) begin
        for (int c = 0; c < NCH; c++)
          if (w_ws == c[0]) r_acc[c] <= r_acc[c] + ACC_W'(w_word[c/2]);
      end
    end
  end

  assign overflow_out = r_ovf;

  // ---------------- stream FSM ----------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
      r_ch    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    case (r_state)
      ST_IDLE:
        if (r_pend) begin
          w_state_nxt = ST_STREAM;
          w_ch_nxt    = '0;
        end
      ST_STREAM:
        if (m_axis_tready) begin
          if (r_ch == CH_LAST) begin
            w_state_nxt = ST_IDLE;
            w_ch_nxt    = '0;
          end else begin
            w_ch_nxt = r_ch + CH_W'(1);
          end
        end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    m_axis_tvalid = (r_state == ST_STREAM);
    m_axis_tdata  = m_axis_tvalid ? r_buf[r_ch] : '0;
    m_axis_tuser  = m_axis_tvalid ? r_ch : '0;
    m_axis_tlast  = m_axis_tvalid && (r_ch == CH_LAST);
  end
endmodule

// File: tb/tb_mic_array_frontend.sv
module tb_mic_array_frontend;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [1:0]  mic_data = '0;
  logic        mic_sck, mic_ws;
  logic [23:0] m_axis_tdata;
  logic [1:0]  m_axis_tuser;
  logic        m_axis_tvalid, m_axis_tlast, overflow_out;
  logic        m_axis_tready = 1'b1;

  mic_array_frontend #(.NUM_LINES(2), .SCK_DIV(16), .DECIM(8), .OUT_W(24)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .mic_data(mic_data),
    .mic_sck(mic_sck), .mic_ws(mic_ws),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .overflow_out(overflow_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {logic [23:0] d; logic [1:0] u; logic l;} beat_t;
  beat_t sb[$];
  int total = 0, bad = 0, ovf_cnt = 0;
  logic [23:0] wl [2][2];   // [line][ws] word transmitted by each mic
  bit alt_mode = 0;

  // first right-slot k=24 capture of frame 7 lands on edge 16+32*(7*64+56);
  // tvalid follows 2 edges later
  localparam int LAT_BATCH = 16 + 32*(7*64 + 56) + 2;   // 16146
  localparam int BATCH_CYC = 8*64*32;                   // 16384

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [23:0] d, input logic [1:0] u, input logic l);
    beat_t b;
    b.d = d; b.u = u; b.l = l;
    sb.push_back(b);
  endtask

  task automatic set_words(input logic [23:0] a, b, c, d);
    wl[0][0] = a; wl[0][1] = b; wl[1][0] = c; wl[1][1] = d;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_sck"},    32'(mic_sck), 0);
    chk({tag, "_ws"},     32'(mic_ws), 0);
    chk({tag, "_tvalid"}, 32'(m_axis_tvalid), 0);
    chk({tag, "_tdata"},  32'(m_axis_tdata), 0);
    chk({tag, "_tuser"},  32'(m_axis_tuser), 0);
    chk({tag, "_tlast"},  32'(m_axis_tlast), 0);
    chk({tag, "_ovf"},    32'(overflow_out), 0);
  endtask

  // I2S microphone model: new bit after every SCK fall, delay bit after a WS change
  initial begin : drv
    int tk;
    logic ps, pw;
    logic [23:0] w;
    tk = 0; ps = 0; pw = 0;
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        tk = 0; ps = 0; pw = 0; mic_data = '0;
      end else begin
        if (ps && !mic_sck) begin
          if (mic_ws != pw) begin
            tk = 0;
            if (alt_mode && !mic_ws) wl[0][0] = (wl[0][0] == 24'h0) ? 24'hFFFFFF : 24'h0;
          end else tk++;
          for (int l = 0; l < 2; l++) begin
            w = wl[l][mic_ws];
            mic_data[l] = (tk >= 1 && tk <= 24) ? w[24-tk] : 1'b0;
          end
        end
        ps = mic_sck; pw = mic_ws;
      end
    end
  end

  // monitor: scoreboard pops on handshake, hold-stability while stalled
  initial begin : mon
    beat_t e;
    logic stalled;
    logic [23:0] hd; logic [1:0] hu; logic hl;
    stalled = 0; hd = '0; hu = '0; hl = 0;
    forever begin
      @(negedge clk_in);
      if (overflow_out) ovf_cnt++;
      if (stalled && m_axis_tvalid) begin
        chk("hold_tdata", 32'(m_axis_tdata), 32'(hd));
        chk("hold_tuser", 32'(m_axis_tuser), 32'(hu));
        chk("hold_tlast", 32'(m_axis_tlast), 32'(hl));
      end
      stalled = m_axis_tvalid && !m_axis_tready;
      hd = m_axis_tdata; hu = m_axis_tuser; hl = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb.size() == 0) chk("unexpected_beat_tuser", 32'(m_axis_tuser), 32'hDEAD);
        else begin
          e = sb.pop_front();
          chk("beat_tdata", 32'(m_axis_tdata), 32'(e.d));
          chk("beat_tuser", 32'(m_axis_tuser), 32'(e.u));
          chk("beat_tlast", 32'(m_axis_tlast), 32'(e.l));
        end
      end
    end
  end

  // SCK 16/16 duty, WS half-period 1024 clk, WS edges on SCK falls
  initial begin : clkchk
    int last_s, last_w;
    logic ps, pw;
    last_s = 0; last_w = 0; ps = 0; pw = 0;
    wait (rst_in == 1'b0);
    @(negedge clk_in);
    for (int c = 1; c <= 8000; c++) begin
      @(negedge clk_in);
      if (mic_sck != ps) begin
        chk("sck_half_period", 32'(c - last_s), 16);
        last_s = c;
      end
      if (mic_ws != pw) begin
        chk("ws_on_sck_fall", {30'b0, ps, mic_sck}, 32'b10);
        chk("ws_half_period", 32'(c - last_w), 1024);
        last_w = c;
      end
      ps = mic_sck; pw = mic_ws;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin : stim
    int n;
    // batch A: every mic constant +1000
    set_words(24'd1000, 24'd1000, 24'd1000, 24'd1000);
    rst_in = 1; m_axis_tready = 1;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 0;
    @(negedge clk_in);
    chk_reset("por");
    for (int c = 0; c < 4; c++) push(24'd1000, 2'(c), c == 3);
    n = 0;
    while (!m_axis_tvalid && n < 20000) begin @(negedge clk_in); n++; end
    chk("a_latency", 32'(n), LAT_BATCH);

    // batch B: ch0 alternates -1/0 per frame (sum -4 -> -1), rest zero
    alt_mode = 1; set_words(24'h0, 24'h0, 24'h0, 24'h0);
    push(24'hFFFFFF, 2'd0, 1'b0);
    push(24'h000000, 2'd1, 1'b0);
    while (m_axis_tvalid && n < 20000) begin @(negedge clk_in); n++; end
    while (!m_axis_tvalid && n < 40000) begin @(negedge clk_in); n++; end
    chk("b_latency", 32'(n), LAT_BATCH + BATCH_CYC);
    alt_mode = 0; set_words(24'd5000, 24'd5000, 24'd5000, 24'd5000);
    // take two beats, then stall mid-batch and let junk accumulate
    @(posedge clk_in); @(posedge clk_in);
    #1 m_axis_tready = 0;
    repeat (6000) @(posedge clk_in);

    // reset mid-frame and mid-stream; batch C carries the boundary words
    #1 rst_in = 1;
    set_words(24'h000100, 24'hFFFFFB, 24'h7FFFFF, 24'h800000);
    @(posedge clk_in);
    #1 rst_in = 0;
    @(negedge clk_in);
    chk_reset("mid");
    n = 0;
    while (!m_axis_tvalid && n < 20000) begin @(negedge clk_in); n++; end
    chk("c_latency", 32'(n), LAT_BATCH);
    push(24'h000100, 2'd0, 1'b0);
    push(24'hFFFFFB, 2'd1, 1'b0);
    push(24'h7FFFFF, 2'd2, 1'b0);
    push(24'h800000, 2'd3, 1'b1);
    // batch D completes while C is still held -> dropped
    set_words(24'd77, 24'd77, 24'd77, 24'd77);
    while (!overflow_out && n < 40000) begin @(negedge clk_in); n++; end
    chk("ovf_time", 32'(n), LAT_BATCH + BATCH_CYC - 1);
    chk("ovf_tvalid_held", 32'(m_axis_tvalid), 1);
    @(negedge clk_in);
    chk("ovf_width", 32'(overflow_out), 0);
    @(posedge clk_in);
    #1 m_axis_tready = 1;
    n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk_in); n++; end
    chk("drain_left", 32'(sb.size()), 0);
    repeat (300) @(negedge clk_in);
    chk("quiet_tvalid", 32'(m_axis_tvalid), 0);
    chk("ovf_count", 32'(ovf_cnt), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
